ofdm_fft_input_sequencer: RTL

//  Parametrised successor to the WIFI RX FFT input controller. Strips a run-time-configurable cyclic prefix
//  (CP) from a continuous OFDM sample stream and ping-pongs symbols through two internal N-deep banks.

---
 rtl/ofdm_fft_input_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ofdm_fft_input_sequencer.sv
// ofdm_fft_input_sequencer: strips the cyclic prefix and ping-pongs symbols
// through two N-deep banks, emitting framed bursts to the FFT core.
module ofdm_fft_input_sequencer #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int FFT_LEN_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FFT_LEN_LOG2-1:0] cfg_cp_len,
    input  logic                    cfg_inverse,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_real,
    input  logic [SAMPLE_WIDTH-1:0] s_imag,
    input  logic                    s_last,
    output logic                    m_start,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SAMPLE_WIDTH-1:0] m_real,
    output logic [SAMPLE_WIDTH-1:0] m_imag,
    output logic [FFT_LEN_LOG2-1:0] m_index,
    output logic                    m_last,
    output logic                    m_inverse,
    output logic                    m_final,
    output logic                    err_overrun
);
    localparam int N  = 2 ** FFT_LEN_LOG2;
    localparam int DW = 2 * SAMPLE_WIDTH;
    localparam int CW = FFT_LEN_LOG2 + 1;

    typedef logic [FFT_LEN_LOG2-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(N - 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(N);

    typedef enum logic [1:0] {STRIP, FILL, PAD} in_state_t;
    typedef enum logic [1:0] {IDLE, START, STREAM} out_state_t;

    logic [DW-1:0] mem [2*N];

    in_state_t     in_state, in_nxt;
    out_state_t    out_state, out_nxt;
    logic          wr_bank, wr_bank_nxt;
    logic          rd_bank, rd_bank_nxt;
    idx_t          wr_addr, wr_addr_nxt;
    idx_t          rd_idx, rd_idx_nxt;
    idx_t          cp_cnt, cp_cnt_nxt;
    idx_t          cp_lat, cp_lat_nxt, cp_use;
    logic          inv_lat, inv_lat_nxt;
    logic          sym_first, first_nxt;
    logic [1:0]    full, full_nxt;
    logic [1:0]    bank_fin, bank_inv;
    logic          accept, wr_en, wr_zero;
    logic          set_full, set_final;
    logic          rd_load, clr_full;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] stall_cnt;

    always_comb begin
        in_nxt      = in_state;
        wr_bank_nxt = wr_bank;
        wr_addr_nxt = wr_addr;
        cp_cnt_nxt  = cp_cnt;
        cp_lat_nxt  = cp_lat;
        inv_lat_nxt = inv_lat;
        first_nxt   = sym_first;
        wr_en       = 1'b0;
        wr_zero     = 1'b0;
        set_full    = 1'b0;
        set_final   = 1'b0;
        accept      = s_valid && s_ready;
        cp_use      = sym_first ? cfg_cp_len : cp_lat;
        unique case (in_state)
            STRIP: if (accept) begin
                first_nxt = 1'b0;
                if (sym_first) begin
                    cp_lat_nxt  = cfg_cp_len;
                    inv_lat_nxt = cfg_inverse;
                end
                // CP exhausted: this sample is already payload addr 0
                if (cp_cnt == cp_use) begin
                    wr_en       = 1'b1;
                    cp_cnt_nxt  = '0;
                    wr_addr_nxt = idx_t'(1);
                    in_nxt      = s_last ? PAD : FILL;
                end else if (s_last) begin
                    cp_cnt_nxt = '0;
                    first_nxt  = 1'b1;
                end else begin
                    cp_cnt_nxt = cp_cnt + 1'b1;
                end
            end
            FILL: if (accept) begin
                wr_en       = 1'b1;
                wr_addr_nxt = wr_addr + 1'b1;
                if (wr_addr == LAST_IDX) begin
                    set_full    = 1'b1;
                    set_final   = s_last;
                    wr_bank_nxt = !wr_bank;
                    first_nxt   = 1'b1;
                    in_nxt      = STRIP;
                end else if (s_last) begin
                    in_nxt = PAD;
                end
            end
            PAD: begin
                wr_en       = 1'b1;
                wr_zero     = 1'b1;
                wr_addr_nxt = wr_addr + 1'b1;
                if (wr_addr == LAST_IDX) begin
                    set_full    = 1'b1;
                    set_final   = 1'b1;
                    wr_bank_nxt = !wr_bank;
                    first_nxt   = 1'b1;
                    in_nxt      = STRIP;
                end
            end
            default: in_nxt = STRIP;
        endcase
    end

    always_comb begin
        out_nxt     = out_state;
        rd_bank_nxt = rd_bank;
        rd_idx_nxt  = rd_idx;
        rd_load     = 1'b0;
        clr_full    = 1'b0;
        unique case (out_state)
            IDLE: if (full[rd_bank]) out_nxt = START;
            START: begin
                rd_load    = 1'b1;
                rd_idx_nxt = '0;
                out_nxt    = STREAM;
            end
            STREAM: if (m_ready) begin
                if (rd_idx == LAST_IDX) begin
                    clr_full    = 1'b1;
                    rd_bank_nxt = !rd_bank;
                    rd_idx_nxt  = '0;
                    out_nxt     = IDLE;
                end else begin
                    rd_load    = 1'b1;
                    rd_idx_nxt = rd_idx + 1'b1;
                end
            end
            default: out_nxt = IDLE;
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (set_full) full_nxt[wr_bank] = 1'b1;
        if (clr_full) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_zero ? '0 : {s_real, s_imag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state  <= STRIP;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            cp_cnt    <= '0;
            cp_lat    <= '0;
            inv_lat   <= 1'b0;
            sym_first <= 1'b1;
            full      <= '0;
            bank_fin  <= '0;
            bank_inv  <= '0;
            s_ready   <= 1'b1;
        end else begin
            in_state  <= in_nxt;
            wr_bank   <= wr_bank_nxt;
            wr_addr   <= wr_addr_nxt;
            cp_cnt    <= cp_cnt_nxt;
            cp_lat    <= cp_lat_nxt;
            inv_lat   <= inv_lat_nxt;
            sym_first <= first_nxt;
            full      <= full_nxt;
            if (set_full) begin
                bank_fin[wr_bank] <= set_final;
                bank_inv[wr_bank] <= inv_lat;
            end
            // ready reflects the state the writer is about to be in
            s_ready <= !full_nxt[wr_bank_nxt] && (in_nxt != PAD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state <= IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            rd_data   <= '0;
        end else begin
            out_state <= out_nxt;
            rd_bank   <= rd_bank_nxt;
            rd_idx    <= rd_idx_nxt;
            if (rd_load) rd_data <= mem[{rd_bank, rd_idx_nxt}];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= '0;
            err_overrun <= 1'b0;
        end else if (s_valid && !s_ready) begin
            if (stall_cnt == STALL_MAX) err_overrun <= 1'b1;
            else stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign m_start   = (out_state == START);
    assign m_valid   = (out_state == STREAM);
    assign m_real    = rd_data[DW-1:SAMPLE_WIDTH];
    assign m_imag    = rd_data[SAMPLE_WIDTH-1:0];
    assign m_index   = rd_idx;
    assign m_last    = m_valid && (rd_idx == LAST_IDX);
    assign m_inverse = (out_state != IDLE) && bank_inv[rd_bank];
    assign m_final   = (out_state != IDLE) && bank_fin[rd_bank];
endmodule
